sweep_ctrl: RTL and testbench

- Sequencer for the 4-bit up/down counter (ports clk/reset/set/up/value, counter output). It drives the counter's set, up, value and reset controls and reads back the counter value.
- It runs programmed sweeps between a low and a high bound, either ramp (lo→hi, reload) or bounce (lo→hi→lo), for a set number of sweeps.
- The counter has no enable, so this block holds the counter by asserting set with value equal to the current count.

---
 rtl/sweep_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sweep_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// sweep_ctrl -- sequencer for an external CNT_W-bit up/down counter.
//
// Runs programmed sweeps between a low and a high bound, either as a ramp
// (lo..hi, then reload lo) or as a bounce (lo..hi..lo), for num_sweeps
// sweeps (0 = run until abort). The counter has no enable, so the counter
// is held by loading it with its own current value.
//
// Optional feature macro: SWEEP_PAUSE_EN adds a 'pause' input. While pause
// is high in UP or DOWN, the counter is held and the sequencer is frozen.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   start       1-cycle pulse, begins a run from IDLE
//   abort       ends an active run (UP/DOWN) at the current count
//   pause       (SWEEP_PAUSE_EN only) freeze the run while high
//   lo, hi      sweep bounds, latched at start
//   bounce      1 = bounce mode, 0 = ramp mode, latched at start
//   num_sweeps  sweeps per run, 0 = unlimited, latched at start
//   counter_in  counter output fed back
//   cnt_reset   counter reset (active-high), follows ~reset combinationally
//   cnt_set     counter synchronous load
//   cnt_up      counter direction when not loading
//   cnt_value   counter load value
//   busy        high in LOAD/UP/DOWN
//   done        1-cycle pulse when a run ends
//   err         1-cycle pulse when a start is rejected (lo > hi)
//   sweep_cnt   completed sweeps in the current or last run (saturates at 15)
module sweep_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef SWEEP_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [CNT_W-1:0] lo,
  input  logic [CNT_W-1:0] hi,
  input  logic             bounce,
  input  logic [3:0]       num_sweeps,
  input  logic [CNT_W-1:0] counter_in,
  output logic             cnt_reset,
  output logic             cnt_set,
  output logic             cnt_up,
  output logic [CNT_W-1:0] cnt_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       sweep_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] lo_l;
  logic [CNT_W-1:0] hi_l;
  logic             bounce_l;
  logic [3:0]       num_l;

  logic             stall;
  logic             at_hi;
  logic             at_lo;
  logic             flat_sweep;
  logic [3:0]       sweep_inc;
  logic             more;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef SWEEP_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign at_hi      = (counter_in == hi_l);
  assign at_lo      = (counter_in == lo_l);
  // A sweep ends at the top edge in ramp mode, and also in bounce mode
  // when the bounds coincide (there is no downward leg to run).
  assign flat_sweep = !bounce_l || (lo_l == hi_l);
  assign sweep_inc  = sat_inc(sweep_cnt);
  assign more       = (num_l == 4'd0) || (sweep_inc < num_l);

  assign cnt_reset  = ~reset;
  assign busy       = (state == LOAD) || (state == UP) || (state == DOWN);

  // Counter control: default is hold (reload the current count).
  always_comb begin
    cnt_set   = 1'b1;
    cnt_up    = 1'b0;
    cnt_value = counter_in;
    case (state)
      LOAD: cnt_value = lo_l;
      UP: begin
        if (!abort && !stall) begin
          if (!at_hi) begin
            cnt_set = 1'b0;
            cnt_up  = 1'b1;
          end else if (flat_sweep) begin
            if (more) cnt_value = lo_l;
          end else begin
            cnt_set = 1'b0;
          end
        end
      end
      DOWN: begin
        if (!abort && !stall) begin
          if (!at_lo) begin
            cnt_set = 1'b0;
          end else if (more) begin
            cnt_set = 1'b0;
            cnt_up  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      sweep_cnt <= 4'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lo <= hi) begin
              lo_l      <= lo;
              hi_l      <= hi;
              bounce_l  <= bounce;
              num_l     <= num_sweeps;
              sweep_cnt <= 4'd0;
              state     <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: state <= UP;
        UP: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (!stall && at_hi) begin
            if (flat_sweep) begin
              sweep_cnt <= sweep_inc;
              if (!more) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              state <= DOWN;
            end
          end
        end
        DOWN: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (!stall && at_lo) begin
            sweep_cnt <= sweep_inc;
            if (more) begin
              state <= UP;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl. A behavioural 4-bit up/down counter
// closes the loop; expected count trajectories are generated from the sweep
// rules as queues of values.
module tb_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, bounce;
  logic [3:0] lo, hi, num_sweeps;
  logic [3:0] counter;
  logic       cnt_reset, cnt_set, cnt_up;
  logic [3:0] cnt_value;
  logic       busy, done, err;
  logic [3:0] sweep_cnt;
`ifdef SWEEP_PAUSE_EN
  logic       pause;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sweep_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .lo(lo), .hi(hi), .bounce(bounce), .num_sweeps(num_sweeps),
    .counter_in(counter), .cnt_reset(cnt_reset), .cnt_set(cnt_set),
    .cnt_up(cnt_up), .cnt_value(cnt_value), .busy(busy), .done(done),
    .err(err), .sweep_cnt(sweep_cnt)
  );

  // External counter being sequenced.
  always @(posedge clk) begin
    if (cnt_reset)    counter <= 4'd0;
    else if (cnt_set) counter <= cnt_value;
    else if (cnt_up)  counter <= counter + 4'd1;
    else              counter <= counter - 4'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; abort = 1'b0; bounce = 1'b0;
    lo = 4'd0; hi = 4'd0; num_sweeps = 4'd0;
`ifdef SWEEP_PAUSE_EN
    pause = 1'b0;
`endif
    tick; tick;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || sweep_cnt !== 4'd0 || cnt_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b err=%b sweep_cnt=%0d cnt_reset=%b, expected 0 0 0 0 1",
               busy, done, err, sweep_cnt, cnt_reset);
    end
    n_checks++;
    if (counter !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_counter: got %0d expected 0", counter);
    end
    reset = 1'b1;
    tick;
    n_checks++;
    if (cnt_reset !== 1'b0 || counter !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: cnt_reset=%b counter=%0d busy=%b expected 0 0 0", cnt_reset, counter, busy);
    end
  endtask

  // Runs one complete sweep run and checks it cycle by cycle against the
  // trajectory implied by the bounds, mode and sweep count.
  task automatic run_sweep(input int a_lo, input int a_hi, input bit a_b,
                           input int a_ns, input int inject, input string name);
    int exp_q[$];
    int last;
    if (a_lo == a_hi) begin
      for (int s = 0; s < a_ns; s++) exp_q.push_back(a_lo);
    end else if (!a_b) begin
      for (int s = 0; s < a_ns; s++)
        for (int v = a_lo; v <= a_hi; v++) exp_q.push_back(v);
    end else begin
      for (int s = 0; s < a_ns; s++) begin
        for (int v = a_lo; v < a_hi; v++) exp_q.push_back(v);
        for (int v = a_hi; v > a_lo; v--) exp_q.push_back(v);
      end
      exp_q.push_back(a_lo);
    end
    last = exp_q[exp_q.size()-1];

    lo = 4'(a_lo); hi = 4'(a_hi); bounce = a_b; num_sweeps = 4'(a_ns);
    start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_load_busy: got %b expected 1", name, busy);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == inject) start = 1'b1;
      tick;
      start = 1'b0;
      n_checks++;
      if (counter !== 4'(exp_q[i]) || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_step%0d: counter=%0d busy=%b done=%b err=%b, expected %0d 1 0 0",
                 name, i, counter, busy, done, err, exp_q[i]);
      end
    end
    tick;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || counter !== 4'(last) || sweep_cnt !== 4'(a_ns)) begin
      n_fail++;
      $display("FAIL %s_done: done=%b busy=%b counter=%0d sweep_cnt=%0d, expected 1 0 %0d %0d",
               name, done, busy, counter, sweep_cnt, last, a_ns);
    end
    tick;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || counter !== 4'(last)) begin
      n_fail++;
      $display("FAIL %s_idle_hold: done=%b busy=%b counter=%0d, expected 0 0 %0d",
               name, done, busy, counter, last);
    end
  endtask

  task automatic test_ramp;
    run_sweep(2, 5, 1'b0, 2, -1, "ramp");
  endtask

  task automatic test_bounce;
    run_sweep(1, 4, 1'b1, 1, -1, "bounce");
  endtask

  task automatic test_bounds;
    logic [3:0] c0;
    c0 = counter;
    lo = 4'd7; hi = 4'd3; bounce = 1'b0; num_sweeps = 4'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bounds_err: err=%b busy=%b expected 1 0", err, busy);
    end
    tick;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0 || counter !== c0) begin
      n_fail++;
      $display("FAIL bounds_after: err=%b busy=%b counter=%0d expected 0 0 %0d", err, busy, counter, c0);
    end
    run_sweep(6, 6, 1'b1, 3, -1, "equal");
  endtask

  task automatic test_abort(input int w, input int p);
    int wexp;
    wexp = (w > 15) ? 15 : w;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: done=%b busy=%b expected 0 0", done, busy);
    end
    lo = 4'd0; hi = 4'd15; bounce = 1'b0; num_sweeps = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 16*w + p; k++) begin
      tick;
      n_checks++;
      if (counter !== 4'(k % 16) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_run_k%0d: counter=%0d busy=%b expected %0d 1", k, counter, busy, k % 16);
      end
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || counter !== 4'(p) || sweep_cnt !== 4'(wexp)) begin
      n_fail++;
      $display("FAIL abort_w%0d_p%0d: done=%b busy=%b counter=%0d sweep_cnt=%0d expected 1 0 %0d %0d",
               w, p, done, busy, counter, sweep_cnt, p, wexp);
    end
    tick;
    n_checks++;
    if (done !== 1'b0 || counter !== 4'(p)) begin
      n_fail++;
      $display("FAIL abort_after: done=%b counter=%0d expected 0 %0d", done, counter, p);
    end
  endtask

  task automatic test_reset_mid;
    lo = 4'd0; hi = 4'd15; bounce = 1'b0; num_sweeps = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 11; k++) tick;
    n_checks++;
    if (counter !== 4'd11) begin
      n_fail++;
      $display("FAIL rstmid_pre: counter=%0d expected 11", counter);
    end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    n_checks++;
    if (counter !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || sweep_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid: counter=%0d busy=%b done=%b sweep_cnt=%0d expected 0 0 0 0",
               counter, busy, done, sweep_cnt);
    end
    tick;
    n_checks++;
    if (done !== 1'b0 || counter !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: done=%b counter=%0d busy=%b expected 0 0 0", done, counter, busy);
    end
  endtask

  task automatic test_start_busy;
    run_sweep(3, 9, 1'b0, 1, 3, "startbusy");
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 8; it++) begin
      int a, b, ns, len, inj;
      bit bm;
      a  = $urandom_range(15);
      b  = $urandom_range(15);
      if (a > b) begin int t; t = a; a = b; b = t; end
      bm = 1'($urandom_range(1));
      ns = $urandom_range(4, 1);
      len = (a == b) ? ns : (bm ? 2*(b-a)*ns + 1 : (b-a+1)*ns);
      inj = (len > 2) ? $urandom_range(len-2, 1) : -1;
      run_sweep(a, b, bm, ns, inj, "rand");
    end
  endtask

`ifdef SWEEP_PAUSE_EN
  task automatic test_pause;
    lo = 4'd0; hi = 4'd10; bounce = 1'b0; num_sweeps = 4'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 4; k++) tick;
    pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick;
      n_checks++;
      if (counter !== 4'd4 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL pause_hold%0d: counter=%0d busy=%b expected 4 1", j, counter, busy);
      end
    end
    pause = 1'b0;
    tick;
    n_checks++;
    if (counter !== 4'd5) begin
      n_fail++;
      $display("FAIL pause_resume: counter=%0d expected 5", counter);
    end
    pause = 1'b1; abort = 1'b1;
    tick;
    pause = 1'b0; abort = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || counter !== 4'd5) begin
      n_fail++;
      $display("FAIL pause_abort: done=%b busy=%b counter=%0d expected 1 0 5", done, busy, counter);
    end
    tick;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ramp;
    test_bounce;
    test_bounds;
    test_abort(2, 9);
    test_abort($urandom_range(18), $urandom_range(15));
    test_abort(17, 15);
    test_reset_mid;
    test_start_busy;
    test_back_to_back;
`ifdef SWEEP_PAUSE_EN
    test_pause;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
